// File: rtl/maxpool_relu.sv
// ReLU followed by non-overlapping POOLxPOOL max-pooling over a captured map.
// Examines one element per clock; writes one pooled slot per window.
module maxpool_relu #(
  parameter int IN_DIM = 3,
  parameter int POOL   = 2,
  parameter int P      = IN_DIM / POOL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IN_DIM*IN_DIM*16-1:0] in_flat,
  output logic [P*P*16-1:0]          out_flat,
  output logic                       busy,
  output logic                       done
);

  localparam int NE = IN_DIM * IN_DIM;
  localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int WW = (P > 1) ? $clog2(P) : 1;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [CW-1:0] CLAST = CW'(POOL - 1);
  localparam logic [WW-1:0] WLAST = WW'(P - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t        state, state_nx;
  logic [15:0]   mem [NE];
  logic [CW-1:0] i, j;
  logic [WW-1:0] pr, pc;
  logic [15:0]   run_max;
  logic [15:0]   elem;
  logic [15:0]   relu;
  logic [IW-1:0] idx;
  logic          win_first;
  logic          win_last;
  logic          map_last;
  logic          capture;

  assign capture   = (state == IDLE) && start;
  assign win_first = (i == '0) && (j == '0);
  assign win_last  = (i == CLAST) && (j == CLAST);
  assign map_last  = (pr == WLAST) && (pc == WLAST);
  assign busy      = (state == SCAN) || (state == WRITE);
  assign done      = (state == DONE);

  always_comb begin
    idx  = IW'((32'(pr) * POOL + 32'(i)) * IN_DIM
               + 32'(pc) * POOL + 32'(j));
    elem = mem[idx];
    relu = elem[15] ? '0 : elem;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SCAN;
      SCAN:  if (win_last) state_nx = WRITE;
      WRITE: state_nx = map_last ? DONE : SCAN;
      DONE:  if (!start) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Map buffer needs no reset: it is always loaded before SCAN reads it.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int k = 0; k < NE; k++)
        mem[k] <= in_flat[k*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      j        <= '0;
      pr       <= '0;
      pc       <= '0;
      run_max  <= '0;
      out_flat <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            out_flat <= '0;
            i        <= '0;
            j        <= '0;
            pr       <= '0;
            pc       <= '0;
          end
        end
        SCAN: begin
          if (win_first || ($signed(relu) > $signed(run_max)))
            run_max <= relu;
          if (j == CLAST) begin
            j <= '0;
            i <= (i == CLAST) ? '0 : i + CW'(1);
          end else begin
            j <= j + CW'(1);
          end
        end
        WRITE: begin
          for (int k = 0; k < P*P; k++)
            if (32'(pr) * P + 32'(pc) == 32'(k))
              out_flat[k*16 +: 16] <= run_max;
          if (pc == WLAST) begin
            pc <= '0;
            pr <= (pr == WLAST) ? '0 : pr + WW'(1);
          end else begin
            pc <= pc + WW'(1);
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule
